// File: rtl/sram_matmul_engine.sv
// rtl/sram_matmul_engine.sv - runtime-sized SRAM matrix-multiply engine (C = A x B or A x B^T)
// One MAC per cycle; each output element is READ (K) + DRAIN (RD_LAT) + WRITE (1) cycles.
module sram_matmul_engine #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dut_valid,
  output logic              dut_ready,
  input  logic [DIM_W-1:0]  cfg_m,
  input  logic [DIM_W-1:0]  cfg_k,
  input  logic [DIM_W-1:0]  cfg_n,
  input  logic [ADDR_W-1:0] cfg_a_base,
  input  logic [ADDR_W-1:0] cfg_b_base,
  input  logic [ADDR_W-1:0] cfg_c_base,
  input  logic              cfg_trans_b,
  output logic [ADDR_W-1:0] dut__tb__sram_input_read_address,
  input  logic [DATA_W-1:0] tb__dut__sram_input_read_data,
  output logic [ADDR_W-1:0] dut__tb__sram_weight_read_address,
  input  logic [DATA_W-1:0] tb__dut__sram_weight_read_data,
  output logic              dut__tb__sram_result_write_enable,
  output logic [ADDR_W-1:0] dut__tb__sram_result_write_address,
  output logic [DATA_W-1:0] dut__tb__sram_result_write_data
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [DIM_W-1:0]  m_q, kd_q, n_q;
  logic [DIM_W-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ADDR_W-1:0] a_base_q, b_base_q, c_base_q;
  logic              trans_q;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [ADDR_W-1:0] a_rd, b_rd, c_wr;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              accept, zero_dim, issue;

  assign accept   = (state_q == S_IDLE) && dut_valid;
  assign zero_dim = (cfg_m == '0) || (cfg_k == '0) || (cfg_n == '0);
  assign issue    = (state_q == S_READ);

  assign a_rd = a_base_q + ADDR_W'(i_q) * ADDR_W'(kd_q) + ADDR_W'(k_q);
  assign b_rd = trans_q ? (b_base_q + ADDR_W'(j_q) * ADDR_W'(kd_q) + ADDR_W'(k_q))
                        : (b_base_q + ADDR_W'(k_q) * ADDR_W'(n_q) + ADDR_W'(j_q));
  assign c_wr = c_base_q + ADDR_W'(i_q) * ADDR_W'(n_q) + ADDR_W'(j_q);

  // Read addresses hold their last issued value outside READ.
  assign a_addr_d = issue ? a_rd : a_addr_q;
  assign b_addr_d = issue ? b_rd : b_addr_q;

  assign dut_ready                          = (state_q == S_IDLE);
  assign dut__tb__sram_input_read_address   = a_addr_d;
  assign dut__tb__sram_weight_read_address  = b_addr_d;
  assign dut__tb__sram_result_write_enable  = (state_q == S_WRITE);
  assign dut__tb__sram_result_write_address = (state_q == S_WRITE) ? c_wr : '0;
  assign dut__tb__sram_result_write_data    = (state_q == S_WRITE) ? acc_q : '0;

  // Valid pipeline tracks which cycles carry returning operand data.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = issue;
    for (int p = 1; p < RD_LAT; p++) vld_d[p] = vld_q[p-1];
  end

  always_comb begin
    acc_d = acc_q;
    if (vld_q[RD_LAT-1]) begin
      acc_d = acc_q + tb__dut__sram_input_read_data * tb__dut__sram_weight_read_data;
    end else if (state_q == S_WRITE || state_q == S_IDLE) begin
      acc_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    lat_d   = lat_q;
    case (state_q)
      S_IDLE: begin
        if (dut_valid) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = zero_dim ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (k_q == kd_q - DIM_W'(1)) begin
          k_d     = '0;
          lat_d   = '0;
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + DIM_W'(1);
        end
      end
      S_DRAIN: begin
        if (lat_q == LAT_W'(RD_LAT - 1)) state_d = S_WRITE;
        else lat_d = lat_q + LAT_W'(1);
      end
      S_WRITE: begin
        if (j_q == n_q - DIM_W'(1)) begin
          j_d = '0;
          if (i_q == m_q - DIM_W'(1)) begin
            state_d = S_IDLE;
          end else begin
            i_d     = i_q + DIM_W'(1);
            state_d = S_READ;
          end
        end else begin
          j_d     = j_q + DIM_W'(1);
          state_d = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      m_q      <= '0;
      kd_q     <= '0;
      n_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      c_base_q <= '0;
      trans_q  <= 1'b0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      lat_q    <= '0;
      vld_q    <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      lat_q    <= lat_d;
      vld_q    <= vld_d;
      acc_q    <= acc_d;
      if (accept) begin
        m_q      <= cfg_m;
        kd_q     <= cfg_k;
        n_q      <= cfg_n;
        a_base_q <= cfg_a_base;
        b_base_q <= cfg_b_base;
        c_base_q <= cfg_c_base;
        trans_q  <= cfg_trans_b;
      end
    end
  end

endmodule

// File: tb/tb_sram_matmul_engine.sv
// tb/tb_sram_matmul_engine.sv - directed bench for sram_matmul_engine (RD_LAT=1 and RD_LAT=3 instances)
module tb_sram_matmul_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, v1, v3, r1, r3;
  logic [7:0]  cm, ck, cn;
  logic [15:0] ca, cb, cc;
  logic        ct;
  logic [15:0] a1, b1, wa1, a3, b3, wa3;
  logic [31:0] ad1, bd1, wd1, ad3, bd3, wd3;
  logic        we1, we3;
  logic [31:0] mem [256];
  logic [31:0] pa [2];
  logic [31:0] pb [2];
  logic [15:0] bh [256];
  int          cyc = 0;
  int          pass_cnt = 0;
  int          total = 0;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    logic [7:0]       m, k, n;
    logic             tr;
    logic [15:0]      ab, bb, cb;
    int               nexp;
    logic [3:0][31:0] exp;
    int               last_rel, ready_rel;
  } vec_t;

  wr_t  w1, w3;
  wr_t  q1 [$];
  wr_t  q3 [$];
  vec_t vt [5];

  sram_matmul_engine #(.DATA_W(32), .ADDR_W(16), .DIM_W(8), .RD_LAT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .dut_valid(v1), .dut_ready(r1),
    .cfg_m(cm), .cfg_k(ck), .cfg_n(cn),
    .cfg_a_base(ca), .cfg_b_base(cb), .cfg_c_base(cc), .cfg_trans_b(ct),
    .dut__tb__sram_input_read_address(a1), .tb__dut__sram_input_read_data(ad1),
    .dut__tb__sram_weight_read_address(b1), .tb__dut__sram_weight_read_data(bd1),
    .dut__tb__sram_result_write_enable(we1), .dut__tb__sram_result_write_address(wa1),
    .dut__tb__sram_result_write_data(wd1)
  );

  sram_matmul_engine #(.DATA_W(32), .ADDR_W(16), .DIM_W(8), .RD_LAT(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .dut_valid(v3), .dut_ready(r3),
    .cfg_m(cm), .cfg_k(ck), .cfg_n(cn),
    .cfg_a_base(ca), .cfg_b_base(cb), .cfg_c_base(cc), .cfg_trans_b(ct),
    .dut__tb__sram_input_read_address(a3), .tb__dut__sram_input_read_data(ad3),
    .dut__tb__sram_weight_read_address(b3), .tb__dut__sram_weight_read_data(bd3),
    .dut__tb__sram_result_write_enable(we3), .dut__tb__sram_result_write_address(wa3),
    .dut__tb__sram_result_write_data(wd3)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    ad1   <= mem[a1[7:0]];
    bd1   <= mem[b1[7:0]];
    pa[0] <= mem[a3[7:0]];
    pa[1] <= pa[0];
    ad3   <= pa[1];
    pb[0] <= mem[b3[7:0]];
    pb[1] <= pb[0];
    bd3   <= pb[1];
  end

  always @(negedge clk) begin
    if (we1) begin
      w1.addr = int'(wa1);
      w1.data = wd1;
      w1.cyc  = cyc;
      q1.push_back(w1);
    end
    if (we3) begin
      w3.addr = int'(wa3);
      w3.data = wd3;
      w3.cyc  = cyc;
      q3.push_back(w3);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  function automatic vec_t mk(input int m, k, n, tr, ab, bb, cbase, nexp,
                              input logic [31:0] e0, e1, e2, e3, input int lr, rr);
    vec_t v;
    v.m = 8'(m); v.k = 8'(k); v.n = 8'(n); v.tr = tr[0];
    v.ab = 16'(ab); v.bb = 16'(bb); v.cb = 16'(cbase);
    v.nexp = nexp;
    v.exp = {e3, e2, e1, e0};
    v.last_rel = lr;
    v.ready_rel = rr;
    return v;
  endfunction

  task automatic drive_cfg(input vec_t v);
    cm = v.m; ck = v.k; cn = v.n; ct = v.tr;
    ca = v.ab; cb = v.bb; cc = v.cb;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int t0;
    int rdy_rel;
    q1.delete();
    @(negedge clk);
    drive_cfg(v);
    v1 = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    v1 = 1'b0;
    rdy_rel = -1;
    for (int rel = 1; rel <= 200; rel++) begin
      @(negedge clk);
      bh[rel] = b1;
      if (rel == 1) check($sformatf("%s ready_low", tag), 32'(r1), 32'd0);
      if (r1 && rel > 1) begin
        rdy_rel = rel;
        break;
      end
    end
    check($sformatf("%s ready_rel", tag), rdy_rel, v.ready_rel);
    check($sformatf("%s nwrites", tag), q1.size(), v.nexp);
    for (int e = 0; e < v.nexp; e++) begin
      if (e < q1.size()) begin
        check($sformatf("%s addr%0d", tag, e), q1[e].addr, 32'(v.cb) + e);
        check($sformatf("%s data%0d", tag, e), q1[e].data, v.exp[e]);
      end
    end
    if (v.nexp > 0 && q1.size() > 0)
      check($sformatf("%s last_rel", tag), q1[q1.size()-1].cyc - t0 + 1, v.last_rel);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t0b, rel_a, rel_b;
    logic [31:0] exp3 [12];

    for (int a = 0; a < 256; a++) mem[a] = 32'd0;
    for (int a = 0; a < 4; a++) mem[a] = 32'(a + 1);
    for (int a = 0; a < 4; a++) mem[16 + a] = 32'(a + 5);
    mem[32] = 32'h7FFF_FFFF; mem[33] = 32'd2;
    mem[34] = 32'hFFFF_FFFD; mem[35] = 32'd4;
    for (int a = 0; a < 12; a++) mem[96 + a] = 32'(a + 1);
    for (int a = 0; a < 8; a++) mem[128 + a] = 32'(a + 1);

    vt[0] = mk(2, 2, 2, 0, 0, 16, 64, 4, 32'd19, 32'd22, 32'd43, 32'd50, 16, 17);
    vt[1] = mk(2, 2, 2, 1, 0, 16, 64, 4, 32'd17, 32'd23, 32'd39, 32'd53, 16, 17);
    vt[2] = mk(1, 1, 1, 0, 32, 33, 80, 1, 32'hFFFF_FFFE, 0, 0, 0, 3, 4);
    vt[3] = mk(1, 1, 1, 0, 34, 35, 81, 1, 32'hFFFF_FFF4, 0, 0, 0, 3, 4);
    vt[4] = mk(2, 2, 0, 0, 0, 16, 90, 0, 0, 0, 0, 0, 0, 2);
    exp3 = '{32'd50, 32'd60, 32'd114, 32'd140, 32'd178, 32'd220,
             32'd30, 32'd70, 32'd70, 32'd174, 32'd110, 32'd278};

    reset_n = 1'b0; v1 = 1'b0; v3 = 1'b0;
    drive_cfg(vt[0]);
    repeat (3) @(negedge clk);
    check("reset ready1", 32'(r1), 32'd1);
    check("reset ready3", 32'(r3), 32'd1);
    check("reset we", 32'(we1), 32'd0);
    check("reset a_addr", 32'(a1), 32'd0);
    check("reset b_addr", 32'(b1), 32'd0);
    check("reset w_addr", 32'(wa1), 32'd0);
    check("reset w_data", wd1, 32'd0);
    reset_n = 1'b1;

    for (int t = 0; t < 5; t++) begin
      run_vec(vt[t], $sformatf("vec%0d", t));
      if (t == 0) begin
        check("nt b_addr e1 k0", 32'(bh[5]), 32'd17);
        check("nt b_addr e1 k1", 32'(bh[6]), 32'd19);
      end
      if (t == 1) begin
        check("tr b_addr e1 k0", 32'(bh[5]), 32'd18);
        check("tr b_addr e1 k1", 32'(bh[6]), 32'd19);
      end
    end

    // Abort during READ of element 1, then prove a fresh job still works.
    q1.delete();
    @(negedge clk);
    drive_cfg(vt[0]);
    v1 = 1'b1;
    @(posedge clk);
    #1;
    v1 = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort we", 32'(we1), 32'd0);
    check("abort ready", 32'(r1), 32'd1);
    check("abort a_addr", 32'(a1), 32'd0);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort nwrites", q1.size(), 32'd1);
    if (q1.size() > 0) check("abort data0", q1[0].data, 32'd19);
    run_vec(vt[0], "post_abort");

    // RD_LAT=3 instance, two 3x4x2 jobs with dut_valid held high.
    q3.delete();
    @(negedge clk);
    cm = 8'd3; ck = 8'd4; cn = 8'd2; ct = 1'b0;
    ca = 16'd96; cb = 16'd128; cc = 16'd160;
    v3 = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    ct = 1'b1; cc = 16'd176;
    rel_a = -1;
    for (int rel = 1; rel <= 300; rel++) begin
      @(negedge clk);
      if (r3) begin
        rel_a = rel;
        break;
      end
    end
    check("lat3 job1 ready_rel", rel_a, 32'd49);
    @(posedge clk);
    #1;
    t0b = cyc;
    v3 = 1'b0;
    check("lat3 job2 accept", t0b - t0, 32'd49);
    rel_b = -1;
    for (int rel = 1; rel <= 300; rel++) begin
      @(negedge clk);
      if (r3 && rel > 1) begin
        rel_b = rel;
        break;
      end
    end
    check("lat3 job2 ready_rel", rel_b, 32'd49);
    check("lat3 nwrites", q3.size(), 32'd12);
    for (int e = 0; e < 12; e++) begin
      if (e < q3.size()) begin
        check($sformatf("lat3 data%0d", e), q3[e].data, exp3[e]);
        check($sformatf("lat3 addr%0d", e), q3[e].addr, (e < 6) ? 160 + e : 176 + e - 6);
        check($sformatf("lat3 cyc%0d", e), q3[e].cyc,
              (e < 6) ? t0 + 8 * (e + 1) - 1 : t0b + 8 * (e - 5) - 1);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
